// File: rtl/cache_fill_arbiter_if.sv
// rtl/cache_fill_arbiter_if.sv - Miss request, fill control and memory read port bundle
//
// Purpose: groups every cache-side and memory-side signal of cache_fill_arbiter.
// Ports (master = arbiter side):
//   in : i_miss, i_miss_addr, d_miss, d_miss_addr  - level miss requests + byte addresses
//   in : mem_valid                                 - returned word valid (fixed latency)
//   out: mem_en, mem_addr                          - memory word read strobe + address
//   out: i_grant, d_grant, set_index               - fill owner and block-enable index
//   out: word_en, i_wr_data, d_wr_data             - data-array word select / write enables
//   out: i_wr_tag, d_wr_tag, i_done, d_done, busy  - tag write, completion pulse, activity
interface cache_fill_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int WORDS  = 8,
   parameter int SET_W  = 6
);
   logic              i_miss;
   logic [ADDR_W-1:0] i_miss_addr;
   logic              d_miss;
   logic [ADDR_W-1:0] d_miss_addr;
   logic              mem_en;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_valid;
   logic              i_grant;
   logic              d_grant;
   logic [SET_W-1:0]  set_index;
   logic [WORDS-1:0]  word_en;
   logic              i_wr_data;
   logic              d_wr_data;
   logic              i_wr_tag;
   logic              d_wr_tag;
   logic              i_done;
   logic              d_done;
   logic              busy;

   modport master (
      input  i_miss, i_miss_addr, d_miss, d_miss_addr, mem_valid,
      output mem_en, mem_addr, i_grant, d_grant, set_index, word_en,
             i_wr_data, d_wr_data, i_wr_tag, d_wr_tag, i_done, d_done, busy
   );

   modport slave (
      output i_miss, i_miss_addr, d_miss, d_miss_addr, mem_valid,
      input  mem_en, mem_addr, i_grant, d_grant, set_index, word_en,
             i_wr_data, d_wr_data, i_wr_tag, d_wr_tag, i_done, d_done, busy
   );
endinterface

// File: rtl/cache_fill_arbiter.sv
// rtl/cache_fill_arbiter.sv - Shared I/D cache miss arbiter and 8-word block fill sequencer
//
// Purpose: grants the single memory read port to one cache miss at a time (data cache
// has priority), issues the block's word reads, steers returned words into the owning
// cache's data array and writes its tag with the last word.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - cache_fill_arbiter_if.master (miss requests, memory port, array write controls)
module cache_fill_arbiter #(
   parameter int ADDR_W = 16,
   parameter int WORDS  = 8,
   parameter int SET_W  = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   cache_fill_arbiter_if.master  bus
);
   localparam int IDX_W = $clog2(WORDS);
   localparam int OFF_W = IDX_W + 1;              // word index + byte-in-word bit
   localparam int CNT_W = $clog2(WORDS + 1);      // counters must be able to hold WORDS
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WORDS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);

   typedef enum logic {IDLE, FILL} state_t;

   state_t                  state, state_nxt;
   logic [CNT_W-1:0]        issue_cnt, recv_cnt;
   logic [ADDR_W-OFF_W-1:0] base_blk;             // block address of the owning miss
   logic                    owner_i, owner_d;
   logic                    issuing;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         issue_cnt <= '0;
         recv_cnt  <= '0;
         base_blk  <= '0;
         owner_i   <= 1'b0;
         owner_d   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE) begin
            // Holding the counters clear in IDLE gives a clean start on every FILL entry.
            issue_cnt <= '0;
            recv_cnt  <= '0;
            if (bus.d_miss) begin
               base_blk <= bus.d_miss_addr[ADDR_W-1:OFF_W];
               owner_d  <= 1'b1;
               owner_i  <= 1'b0;
            end else if (bus.i_miss) begin
               base_blk <= bus.i_miss_addr[ADDR_W-1:OFF_W];
               owner_i  <= 1'b1;
               owner_d  <= 1'b0;
            end
         end else begin
            if (issuing)
               issue_cnt <= issue_cnt + 1'b1;
            if (bus.mem_valid)
               recv_cnt <= recv_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      issuing       = 1'b0;
      bus.mem_en    = 1'b0;
      bus.mem_addr  = '0;
      bus.i_grant   = 1'b0;
      bus.d_grant   = 1'b0;
      bus.set_index = '0;
      bus.word_en   = '0;
      bus.i_wr_data = 1'b0;
      bus.d_wr_data = 1'b0;
      bus.i_wr_tag  = 1'b0;
      bus.d_wr_tag  = 1'b0;
      bus.i_done    = 1'b0;
      bus.d_done    = 1'b0;
      bus.busy      = 1'b0;
      case (state)
         IDLE: begin
            // mem_valid is deliberately ignored here.
            if (bus.d_miss || bus.i_miss)
               state_nxt = FILL;
         end
         FILL: begin
            bus.busy      = 1'b1;
            bus.i_grant   = owner_i;
            bus.d_grant   = owner_d;
            bus.set_index = base_blk[SET_W-1:0];
            if (issue_cnt < CNT_MAX) begin
               issuing      = 1'b1;
               bus.mem_en   = 1'b1;
               bus.mem_addr = {base_blk, issue_cnt[IDX_W-1:0], 1'b0};
            end
            if (bus.mem_valid) begin
               bus.word_en[recv_cnt[IDX_W-1:0]] = 1'b1;
               bus.i_wr_data = owner_i;
               bus.d_wr_data = owner_d;
               // Tag (and valid bit) is written only with the final word, so an aborted
               // fill leaves the block invalid.
               if (recv_cnt == CNT_LAST) begin
                  bus.i_wr_tag = owner_i;
                  bus.d_wr_tag = owner_d;
                  bus.i_done   = owner_i;
                  bus.d_done   = owner_d;
                  state_nxt    = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: doc/cache_fill_arbiter.md
Name: cache_fill_arbiter

Overview:
- Miss-handling controller shared by the instruction and data caches.
- Accepts miss requests from both caches and grants the single main-memory read port to one cache at a time.
- Sequences an 8-word block fill: issues the word reads, steers returned words into the granted cache's data array, then writes its tag.
- Drives the 6-bit set index to that cache's block-enable decoder, which selects 1 of 64 blocks.

Parameters:
- ADDR_W, 16, byte-address width.
- WORDS, 8, 16-bit words per block (block = 16 bytes).
- SET_W, 6, set-index width (64 sets).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_miss  in  1  instruction-cache miss request, level; held until i_done.
- i_miss_addr  in  ADDR_W  instruction miss byte address.
- d_miss  in  1  data-cache miss request, level; held until d_done.
- d_miss_addr  in  ADDR_W  data miss byte address.
- mem_en  out  1  memory read strobe, one word per cycle.
- mem_addr  out  ADDR_W  memory read word address.
- mem_valid  in  1  returned word valid; arrives a fixed 4 cycles after the matching mem_en, in order.
- i_grant, d_grant  out  1 each  which cache owns the current fill.
- set_index  out  SET_W  addr[9:4] of the owning miss; feeds the block-enable decoder.
- word_en  out  WORDS  one-hot word select for the data-array write.
- i_wr_data, d_wr_data  out  1 each  data-array write enable of the owning cache.
- i_wr_tag, d_wr_tag  out  1 each  tag-array write enable, including valid-bit set.
- i_done, d_done  out  1 each  one-cycle fill-complete pulse.
- busy  out  1  high in any non-IDLE state.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; issue_cnt=0, recv_cnt=0; owner cleared. All outputs 0, set_index=0, mem_addr=0.
- States:
  - IDLE: if d_miss, latch d_miss_addr and set owner=D; else if i_miss, latch i_miss_addr and set owner=I; then go to FILL next cycle. Fixed priority is D over I. Simultaneous requests grant D; I waits and is granted on the next IDLE evaluation.
  - FILL:
    - Issue: mem_en=1 while issue_cnt<WORDS. mem_addr = {base[15:4], issue_cnt, 1'b0}, where base is the latched address. issue_cnt increments each issuing cycle and saturates at WORDS.
    - Receive: on mem_valid, word_en=onehot(recv_cnt), the owner's wr_data=1, and recv_cnt increments.
    - On the cycle mem_valid arrives with recv_cnt==WORDS-1: owner's wr_tag=1 and owner's done=1 in that same cycle; next state is IDLE.
  - Grant and index: i_grant/d_grant and set_index are stable for the whole FILL and are 0 in IDLE. grant and busy assert the cycle after acceptance and drop on return to IDLE.
- Timing with 4-cycle memory: request seen at cycle 0. Issues occur in cycles 1-8. Returns occur in cycles 5-12, with the tag write and done pulse in cycle 12. IDLE is reached in cycle 13, and a pending miss is accepted in cycle 13.
- Latched address: the miss address is captured once at acceptance; later changes on the miss_addr inputs have no effect.
- Edge cases:
  - Requests arriving while busy are not lost; they are held by the requester and served later.
  - mem_valid in IDLE is ignored; no write enables assert.
  - mem_valid beyond WORDS returns is impossible by construction (issue count saturates).
  - Reset mid-fill aborts immediately: no tag write, no done, and the partially written block stays invalid because the tag is not written.
  - The requester deasserts its miss in the cycle after its done pulse. If i_miss is still high in that cycle it is treated as a new miss.
- Counters: issue_cnt and recv_cnt are 4 bits (0..8); both clear on entry to FILL.

Test Plan:
- Single D miss at 0x1234 -> mem_addr sequence 0x1230, 0x1232, … 0x123E in cycles 1-8. set_index=0x23. word_en walks 0x01..0x80 in cycles 5-12. d_wr_tag and d_done in cycle 12. No i_* activity.
- Simultaneous i_miss (0x0040) and d_miss (0x8080) -> D fill first with set_index=0x08. I is accepted in cycle 13 with set_index=0x04. i_done in cycle 25.
- d_miss_addr changed to 0xFFFF mid-fill -> mem_addr continues the latched block. set_index unchanged.
- rst_n low in cycle 7 of a fill -> all outputs 0 immediately; no tag write or done. A fresh miss after reset fills normally.
- mem_valid pulsed while IDLE -> no wr_data, word_en=0, state remains IDLE.
- Back-to-back D misses on sets 63 then 0 -> set_index=0x3F then 0x00. Exactly 8 data writes and 1 tag write per fill.
